// File: rtl/conv2d_loop_sequencer.sv
// Loop-nest sequencer for a stride-1 2D convolution: walks oc/oy/ox/ic/ky/kx
// and presents one MAC beat per cycle with input, weight and output addresses.
module conv2d_loop_sequencer #(
    parameter int IMG  = 6,
    parameter int KSZ  = 3,
    parameter int CIN  = 2,
    parameter int COUT = 2,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          mac_valid,
    input  logic          mac_ready,
    output logic          mac_first,
    output logic          mac_last,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] out_addr,
    output logic [AW-1:0] out_count
);
    localparam int OW    = IMG - KSZ + 1;
    localparam int NLOOP = 6;
    localparam int MAXD  = (IMG > CIN) ? ((IMG > COUT) ? IMG : COUT)
                                       : ((CIN > COUT) ? CIN : COUT);
    localparam int CW    = $clog2(MAXD + 1);
    // Loop limits, innermost first: kx, ky, ic, ox, oy, oc
    localparam int LIM [NLOOP] = '{KSZ, KSZ, CIN, OW, OW, COUT};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       out_count_reg;
    logic [NLOOP*CW-1:0] cnt_flat;
    logic [NLOOP-1:0]    at_max;
    logic [NLOOP:0]      carry;
    logic                run, beat_fire, cnt_clear, final_beat;
    logic [CW-1:0]       kx, ky, ic, ox, oy, oc;

    assign run        = (state_reg == RUN);
    assign beat_fire  = run && mac_ready;
    assign cnt_clear  = ((state_reg == IDLE) && start) || (run && abort);
    assign carry[0]   = beat_fire;
    assign final_beat = carry[NLOOP];

    // Ripple-carry counter chain; a counter steps only when every inner one wraps
    generate
        for (genvar gi = 0; gi < NLOOP; gi++) begin : g_cnt
            logic [CW-1:0] cnt_reg;

            assign at_max[gi]              = (cnt_reg == CW'(LIM[gi] - 1));
            assign carry[gi+1]             = carry[gi] && at_max[gi];
            assign cnt_flat[gi*CW +: CW]   = cnt_reg;

            always_ff @(posedge clk) begin
                if (!rst_n || cnt_clear) begin
                    cnt_reg <= '0;
                end else if (carry[gi]) begin
                    cnt_reg <= at_max[gi] ? '0 : cnt_reg + CW'(1);
                end
            end
        end
    endgenerate

    assign kx = cnt_flat[0*CW +: CW];
    assign ky = cnt_flat[1*CW +: CW];
    assign ic = cnt_flat[2*CW +: CW];
    assign ox = cnt_flat[3*CW +: CW];
    assign oy = cnt_flat[4*CW +: CW];
    assign oc = cnt_flat[5*CW +: CW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Abort wins over a coincident final beat, so no done pulse follows it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (abort)           state_next = IDLE;
                else if (final_beat) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_count_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            out_count_reg <= '0;
        end else if (beat_fire && mac_last) begin
            out_count_reg <= out_count_reg + AW'(1);
        end
    end

    assign busy      = run;
    assign done      = (state_reg == DONE);
    assign mac_valid = run;
    assign mac_first = run && (ic == '0) && (ky == '0) && (kx == '0);
    assign mac_last  = run && at_max[2] && at_max[1] && at_max[0];
    assign out_count = out_count_reg;

    // Counters idle at zero, so the addresses read 0 outside RUN
    assign in_addr  = AW'(ic) * AW'(IMG * IMG)
                    + (AW'(oy) + AW'(ky)) * AW'(IMG)
                    + AW'(ox) + AW'(kx);
    assign w_addr   = ((AW'(oc) * AW'(CIN) + AW'(ic)) * AW'(KSZ) + AW'(ky)) * AW'(KSZ)
                    + AW'(kx);
    assign out_addr = AW'(oc) * AW'(OW * OW) + AW'(oy) * AW'(OW) + AW'(ox);
endmodule

// File: tb/tb_conv2d_loop_sequencer.sv
// Directed bench for conv2d_loop_sequencer: full passes with steady and
// random ready, aborts, mid-pass reset and ignored start pulses.
module tb_conv2d_loop_sequencer;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mac_ready = 1'b0;
    logic          busy, done, mac_valid, mac_first, mac_last;
    logic [AW-1:0] in_addr, w_addr, out_addr, out_count;

    int tests_run = 0;
    int tests_failed = 0;

    conv2d_loop_sequencer #(
        .IMG(6), .KSZ(3), .CIN(2), .COUT(2), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_first(mac_first), .mac_last(mac_last),
        .in_addr(in_addr), .w_addr(w_addr), .out_addr(out_addr),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference loop nest: beat n decomposed as oc,oy,ox,ic,ky,kx for 6x6, k3, 2->2
    task automatic expect_beat(input int n, output int ia, output int wa, output int oa,
                               output int f, output int l);
        int kx, ky, ic, ox, oy, oc;
        kx = n % 3;
        ky = (n / 3) % 3;
        ic = (n / 9) % 2;
        ox = (n / 18) % 4;
        oy = (n / 72) % 4;
        oc = n / 288;
        ia = ic * 36 + (oy + ky) * 6 + (ox + kx);
        wa = ((oc * 2 + ic) * 3 + ky) * 3 + kx;
        oa = oc * 16 + oy * 4 + ox;
        f  = (n % 18 == 0) ? 1 : 0;
        l  = (n % 18 == 17) ? 1 : 0;
    endtask

    // Hand-computed spot beats: {beat, in_addr, w_addr, out_addr}
    int spot [4][4] = '{'{0, 0, 0, 0}, '{17, 50, 17, 0}, '{18, 1, 0, 1}, '{575, 71, 35, 31}};

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_valid"}, mac_valid, 0);
        check_eq({tag, "_first"}, mac_first, 0);
        check_eq({tag, "_last"}, mac_last, 0);
        check_eq({tag, "_in"}, in_addr, 0);
        check_eq({tag, "_w"}, w_addr, 0);
        check_eq({tag, "_out"}, out_addr, 0);
    endtask

    // Runs one pass from IDLE; called and returning on a negative edge
    task automatic run_pass(input string tag, input int ready_pct, input int abort_at,
                            input int glitch_cyc, input bit glitch_done,
                            output int beats, output int busy_cycles, output int saw_done);
        int cyc, ia, wa, oa, f, l;
        bit rdy;
        beats = 0;
        busy_cycles = 0;
        cyc = 0;
        start = 1'b1;
        @(negedge clk);
        while (cyc < 5000 && busy) begin
            busy_cycles++;
            expect_beat(beats, ia, wa, oa, f, l);
            check_eq({tag, "_valid"}, mac_valid, 1);
            check_eq({tag, "_done_in_run"}, done, 0);
            check_eq({tag, "_in"}, in_addr, ia);
            check_eq({tag, "_w"}, w_addr, wa);
            check_eq({tag, "_out"}, out_addr, oa);
            check_eq({tag, "_first"}, mac_first, f);
            check_eq({tag, "_last"}, mac_last, l);
            check_eq({tag, "_ocount"}, out_count, beats / 18);
            for (int s = 0; s < 4; s++) begin
                if (spot[s][0] == beats) begin
                    check_eq({tag, "_spot_in"}, in_addr, spot[s][1]);
                    check_eq({tag, "_spot_w"}, w_addr, spot[s][2]);
                    check_eq({tag, "_spot_out"}, out_addr, spot[s][3]);
                end
            end
            rdy = ($urandom_range(99) < ready_pct) || (beats == abort_at);
            mac_ready = rdy;
            abort = (beats == abort_at);
            start = (cyc == glitch_cyc);
            if (rdy) beats++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_ended"}, busy, 0);
        saw_done = done;
        mac_ready = 1'b0;
        abort = 1'b0;
        start = glitch_done && done;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_done_one_cycle"}, done, 0);
        check_eq({tag, "_idle_after"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "_no_restart"}, busy, 0);
        $display("[TB] %s: beats=%0d busy_cycles=%0d done=%0d out_count=%0d",
                 tag, beats, busy_cycles, saw_done, out_count);
    endtask

    initial begin
        int beats, bcyc, sdone;

        // Reset with start held: nothing may start
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        check_eq("reset_ocount", out_count, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("post_reset_idle", busy, 0);

        run_pass("full_rdy", 100, -1, -1, 1'b0, beats, bcyc, sdone);
        check_eq("full_rdy_beats", beats, 576);
        check_eq("full_rdy_busy", bcyc, 576);
        check_eq("full_rdy_done", sdone, 1);
        check_eq("full_rdy_ocount", out_count, 32);
        check_idle_zero("full_rdy_idle");

        run_pass("rand_rdy", 50, -1, 10, 1'b1, beats, bcyc, sdone);
        check_eq("rand_rdy_beats", beats, 576);
        check_eq("rand_rdy_done", sdone, 1);
        check_eq("rand_rdy_ocount", out_count, 32);

        run_pass("abort100", 100, 100, -1, 1'b0, beats, bcyc, sdone);
        check_eq("abort100_beats", beats, 101);
        check_eq("abort100_done", sdone, 0);
        check_eq("abort100_ocount", out_count, 5);
        check_idle_zero("abort100_idle");

        run_pass("abort_last", 100, 575, -1, 1'b0, beats, bcyc, sdone);
        check_eq("abort_last_beats", beats, 576);
        check_eq("abort_last_done", sdone, 0);
        check_eq("abort_last_ocount", out_count, 32);

        run_pass("restart", 100, -1, 300, 1'b1, beats, bcyc, sdone);
        check_eq("restart_beats", beats, 576);
        check_eq("restart_done", sdone, 1);

        // Mid-pass reset with start held high
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mac_ready = 1'b1;
        repeat (50) @(negedge clk);
        check_eq("midrst_running", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_idle_zero("midrst");
        check_eq("midrst_ocount", out_count, 0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("midrst_no_start", busy, 0);
        @(negedge clk);
        check_eq("midrst_still_idle", busy, 0);
        mac_ready = 1'b0;
        $display("[TB] midrst: busy=%0d out_count=%0d", busy, out_count);

        run_pass("after_rst", 50, -1, -1, 1'b0, beats, bcyc, sdone);
        check_eq("after_rst_beats", beats, 576);
        check_eq("after_rst_done", sdone, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
